// File: rtl/dmem_responder_if.sv
// Load/store bus between the pipeline's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_read_en;
    logic                  dmem_write_en;
    logic [2:0]            func3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  busy;
    logic                  access_err;

    modport master (
        output dmem_read_en, dmem_write_en, func3, addr, wdata,
        input  rdata, rdata_valid, busy, access_err
    );

    modport slave (
        input  dmem_read_en, dmem_write_en, func3, addr, wdata,
        output rdata, rdata_valid, busy, access_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte/half/word stores completing in one
// edge and loads answered through an IDLE -> READ -> RESP sequence.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input logic            clk,
    input logic            rst_n,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      word_idx;
    logic                  req_err;
    logic                  load_go;
    logic                  store_go;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata_lanes;

    logic [IDX_W-1:0]      idx_p0;
    logic [1:0]            lane_p0;
    logic [2:0]            func3_p0;

    logic                  unused_addr_bits;

    function automatic logic access_error(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] lsb);
        logic illegal;
        logic misaligned;
        if (rd)
            illegal = (f3[1] && f3[0]) || (f3[2] && f3[1]);
        else
            illegal = f3[2] || (f3[1] && f3[0]);
        misaligned = ((f3[1:0] == 2'b01) && lsb[0]) ||
                     ((f3[1:0] == 2'b10) && (lsb != 2'b00));
        return (rd && wr) || illegal || misaligned;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] format_load(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0]            lane,
                                                          input logic [2:0]            f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return DATA_WIDTH'(b);
            3'b100:  return DATA_WIDTH'($unsigned(b));
            3'b001:  return DATA_WIDTH'(h);
            3'b101:  return DATA_WIDTH'($unsigned(h));
            default: return word;
        endcase
    endfunction

    assign word_idx         = bus.addr[IDX_W+1:2];
    assign unused_addr_bits = ^bus.addr[DATA_WIDTH-1:IDX_W+2];

    // Requests only count in IDLE; anything presented while busy is dropped.
    always_comb begin
        req_err  = 1'b0;
        load_go  = 1'b0;
        store_go = 1'b0;
        if (state == IDLE && (bus.dmem_read_en || bus.dmem_write_en)) begin
            req_err  = access_error(bus.dmem_read_en, bus.dmem_write_en,
                                    bus.func3, bus.addr[1:0]);
            load_go  = bus.dmem_read_en  && !req_err;
            store_go = bus.dmem_write_en && !req_err;
        end
    end

    always_comb begin
        wdata_lanes = bus.wdata;
        byte_en     = 4'b1111;
        case (bus.func3[1:0])
            2'b00: begin
                wdata_lanes = {4{bus.wdata[7:0]}};
                byte_en     = 4'b0001 << bus.addr[1:0];
            end
            2'b01: begin
                wdata_lanes = {2{bus.wdata[15:0]}};
                byte_en     = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Sampling edge: stores land in storage, loads latch what READ needs.
    always_ff @(posedge clk) begin
        if (store_go) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
        if (load_go) begin
            idx_p0   <= word_idx;
            lane_p0  <= bus.addr[1:0];
            func3_p0 <= bus.func3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.access_err  <= 1'b0;
        end else begin
            bus.access_err  <= req_err;
            bus.rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_go) begin
                        state    <= READ;
                        bus.busy <= 1'b1;
                    end
                end
                // READ edge: word captured and formatted straight into rdata.
                READ: begin
                    bus.rdata       <= format_load(mem[idx_p0], lane_p0, func3_p0);
                    bus.rdata_valid <= 1'b1;
                    state           <= RESP;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the load/store data and address buses.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words in storage; the word index is addr[log2(DEPTH)+1:2].
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port dmem_read_en  input  1  load request from the controller.
REQ-006 Port dmem_write_en  input  1  store request from the controller.
REQ-007 Port func3  input  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 Port addr  input  32  byte address, from the ALU result.
REQ-009 Port wdata  input  32  store data, from rs2; the low byte or low half is used for sb and sh.
REQ-010 Port rdata  output  32  formatted load data.
REQ-011 Port rdata_valid  output  1  one-cycle pulse; rdata is valid while it is high.
REQ-012 Port busy  output  1  a load is in flight; new requests are ignored while it is high.
REQ-013 Port access_err  output  1  one-cycle pulse for a rejected request.

Function
REQ-014 The FSM SHALL have three states: IDLE, READ and RESP.
REQ-015 A request SHALL be sampled only in IDLE; while busy=1, the enables are ignored with no side effects.
REQ-016 A store SHALL complete at the sampling edge; the FSM stays in IDLE, busy stays 0 and there is no response pulse.
REQ-017 Store lanes: sb writes lane addr[1:0] with wdata[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian; sw writes all four lanes.
REQ-018 A load SHALL go IDLE->READ at the sampling edge and latch addr[1:0] and func3.
REQ-019 In READ, busy=1, and the addressed word SHALL be captured into an internal register at the edge; the FSM then goes READ->RESP.
REQ-020 In RESP, busy=1 and rdata_valid=1, and rdata SHALL hold the formatted data; the FSM then goes RESP->IDLE.
REQ-021 Load latency SHALL be exactly 2 cycles from the sampling edge to rdata_valid, giving back-to-back loads every 3 cycles.
REQ-022 Load formatting: lb/lbu select the byte at addr[1:0]; lh/lhu select the half at addr[1]; lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
REQ-023 Outside RESP, rdata SHALL hold its last value; it is 0 after reset.
REQ-024 Misalignment is an error: h/hu with addr[0]=1, or w with addr[1:0]!=00.
REQ-025 Illegal func3 is an error: loads 011, 110, 111; stores 011 through 111.
REQ-026 dmem_read_en=1 together with dmem_write_en=1 is an error.
REQ-027 On any error, storage SHALL be unchanged, the FSM stays in IDLE, access_err=1 for the next cycle only, and rdata_valid is not asserted.
REQ-028 Address bits above the word index SHALL be ignored, so addresses wrap modulo DEPTH*4 bytes.
REQ-029 A load following a store to the same word SHALL return the stored data, because the store completes before the load is sampled.

Reset
REQ-030 While rst_n=0, asynchronously: FSM=IDLE, rdata=0, rdata_valid=0, busy=0, access_err=0.
REQ-031 Storage contents are not reset and are undefined until written.
REQ-032 Reset asserted in READ or RESP SHALL abort the load with no rdata_valid pulse; the first request after reset release is serviced normally.

Verification
REQ-033 Store/load word: sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 -> rdata_valid exactly 2 cycles after sampling, rdata=0xDEADBEEF, busy high for 2 cycles.
REQ-034 Byte lanes: sw 0x10 0x11223344, then sb 0x13 wdata 0x000000A0 -> lw 0x10 returns 0xA0223344, lb 0x13 returns 0xFFFFFFA0, lbu 0x13 returns 0x000000A0.
REQ-035 Halfwords: after REQ-034, lh 0x12 returns 0xFFFFA022 and lhu 0x12 returns 0x0000A022; sh 0x10 wdata 0x5566 -> lw 0x10 returns 0xA0225566.
REQ-036 Errors: lw 0x06, sh 0x11, load func3=011, and read+write together -> access_err pulses once for each, no rdata_valid, and lw 0x10 afterwards still returns 0xA0225566.
REQ-037 Busy/abort: a request during busy is ignored; rst_n low in READ -> outputs go to 0 immediately with no rdata_valid; lw 0x10 after release returns 0xA0225566.
REQ-038 Wrap: with DEPTH=256, sw 0x400 wdata 0x12345678 -> lw 0x000 returns 0x12345678.
